// File: rtl/regwb_arbiter.sv
// Register-file write-back arbiter: two buffered producer channels, round-robin
// grant, registered write port and per-register pending scoreboard.
// Optional commit counter port enabled by defining WB_COMMIT_CNT_EN.
module regwb_arbiter #(
   parameter int REG_ADDRW = 5,
   parameter int CPU_WIDTH = 64,
   parameter int REG_COUNT = 32
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic                 i_alu_valid,
   output logic                 o_alu_ready,
   input  logic [REG_ADDRW-1:0] i_alu_rd,
   input  logic [CPU_WIDTH-1:0] i_alu_data,
   input  logic                 i_lsu_valid,
   output logic                 o_lsu_ready,
   input  logic [REG_ADDRW-1:0] i_lsu_rd,
   input  logic [CPU_WIDTH-1:0] i_lsu_data,
   input  logic                 i_issue_valid,
   input  logic [REG_ADDRW-1:0] i_issue_rd,
   output logic                 o_wen,
   output logic [REG_ADDRW-1:0] o_waddr,
   output logic [CPU_WIDTH-1:0] o_wdata,
`ifdef WB_COMMIT_CNT_EN
   output logic [63:0]          o_commit_cnt,
`endif
   output logic [REG_COUNT-1:0] o_busy
);

   typedef enum logic {PTR_LSU, PTR_ALU} ptr_t;

   ptr_t                 ptr_q, ptr_d;
   logic                 alu_hold_v, lsu_hold_v;
   logic [REG_ADDRW-1:0] alu_hold_rd, lsu_hold_rd;
   logic [CPU_WIDTH-1:0] alu_hold_data, lsu_hold_data;
   logic                 grant_alu, grant_lsu, grant_any;
   logic [REG_ADDRW-1:0] gnt_rd;
   logic [CPU_WIDTH-1:0] gnt_data;
   logic                 alu_hs, lsu_hs;
   logic [REG_COUNT-1:0] busy_d;

   // Pointer only moves when both buffers compete for the port.
   always_comb begin
      grant_alu = 1'b0;
      grant_lsu = 1'b0;
      ptr_d     = ptr_q;
      if (alu_hold_v && lsu_hold_v) begin
         if (ptr_q == PTR_LSU) begin
            grant_lsu = 1'b1;
            ptr_d     = PTR_ALU;
         end else begin
            grant_alu = 1'b1;
            ptr_d     = PTR_LSU;
         end
      end else begin
         grant_alu = alu_hold_v;
         grant_lsu = lsu_hold_v;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) ptr_q <= PTR_LSU;
      else          ptr_q <= ptr_d;
   end

   assign grant_any   = grant_alu | grant_lsu;
   assign gnt_rd      = grant_lsu ? lsu_hold_rd   : alu_hold_rd;
   assign gnt_data    = grant_lsu ? lsu_hold_data : alu_hold_data;
   assign o_alu_ready = ~alu_hold_v | grant_alu;
   assign o_lsu_ready = ~lsu_hold_v | grant_lsu;
   assign alu_hs      = i_alu_valid & o_alu_ready;
   assign lsu_hs      = i_lsu_valid & o_lsu_ready;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         alu_hold_v    <= 1'b0;
         alu_hold_rd   <= '0;
         alu_hold_data <= '0;
      end else if (alu_hs) begin
         alu_hold_v    <= 1'b1;
         alu_hold_rd   <= i_alu_rd;
         alu_hold_data <= i_alu_data;
      end else if (grant_alu) begin
         alu_hold_v    <= 1'b0;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         lsu_hold_v    <= 1'b0;
         lsu_hold_rd   <= '0;
         lsu_hold_data <= '0;
      end else if (lsu_hs) begin
         lsu_hold_v    <= 1'b1;
         lsu_hold_rd   <= i_lsu_rd;
         lsu_hold_data <= i_lsu_data;
      end else if (grant_lsu) begin
         lsu_hold_v    <= 1'b0;
      end
   end

   // Address/data keep their last value when idle; only the enable drops.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_wen   <= 1'b0;
         o_waddr <= '0;
         o_wdata <= '0;
      end else begin
         o_wen <= grant_any & (gnt_rd != '0);
         if (grant_any) begin
            o_waddr <= gnt_rd;
            o_wdata <= gnt_data;
         end
      end
   end

   // Set is applied after clear so a same-edge reissue keeps the bit pending.
   always_comb begin
      busy_d = o_busy;
      if (o_wen)         busy_d[o_waddr]    = 1'b0;
      if (i_issue_valid) busy_d[i_issue_rd] = 1'b1;
      busy_d[0] = 1'b0;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) o_busy <= '0;
      else          o_busy <= busy_d;
   end

`ifdef WB_COMMIT_CNT_EN
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) o_commit_cnt <= '0;
      else          o_commit_cnt <= o_commit_cnt + {63'd0, grant_any};
   end
`endif

endmodule

// File: tb/tb_regwb_arbiter.sv
// Self-checking bench for regwb_arbiter: per-channel expected-write queues fed on
// handshake, a negedge monitor matching write-port beats, plus timed directed checks.
module tb_regwb_arbiter;

   localparam int AW = 5;
   localparam int DW = 64;
   localparam int RC = 32;

   logic          i_clk = 1'b0;
   logic          i_rst_n = 1'b0;
   logic          i_alu_valid = 1'b0, i_lsu_valid = 1'b0, i_issue_valid = 1'b0;
   logic [AW-1:0] i_alu_rd = '0, i_lsu_rd = '0, i_issue_rd = '0;
   logic [DW-1:0] i_alu_data = '0, i_lsu_data = '0;
   logic          o_alu_ready, o_lsu_ready, o_wen;
   logic [AW-1:0] o_waddr;
   logic [DW-1:0] o_wdata;
   logic [RC-1:0] o_busy;
`ifdef WB_COMMIT_CNT_EN
   logic [63:0]   o_commit_cnt;
`endif

   regwb_arbiter #(.REG_ADDRW(AW), .CPU_WIDTH(DW), .REG_COUNT(RC)) dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n),
      .i_alu_valid(i_alu_valid), .o_alu_ready(o_alu_ready),
      .i_alu_rd(i_alu_rd), .i_alu_data(i_alu_data),
      .i_lsu_valid(i_lsu_valid), .o_lsu_ready(o_lsu_ready),
      .i_lsu_rd(i_lsu_rd), .i_lsu_data(i_lsu_data),
      .i_issue_valid(i_issue_valid), .i_issue_rd(i_issue_rd),
      .o_wen(o_wen), .o_waddr(o_waddr), .o_wdata(o_wdata),
`ifdef WB_COMMIT_CNT_EN
      .o_commit_cnt(o_commit_cnt),
`endif
      .o_busy(o_busy)
   );

   always #5 i_clk = ~i_clk;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;
   int unsigned cyc      = 0;
   int unsigned matched  = 0;

   typedef struct packed { logic [AW-1:0] rd; logic [DW-1:0] data; } beat_t;
   beat_t q_alu[$];
   beat_t q_lsu[$];

   logic          log_wen  [4096];
   logic [AW-1:0] log_addr [4096];
   logic [DW-1:0] log_data [4096];
   logic [RC-1:0] log_busy [4096];

   always @(posedge i_clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Handshakes become expected writes; rd==0 beats must never appear on the port.
   always @(negedge i_clk) begin
      if (i_rst_n) begin
         if (i_alu_valid && o_alu_ready && i_alu_rd != '0) q_alu.push_back({i_alu_rd, i_alu_data});
         if (i_lsu_valid && o_lsu_ready && i_lsu_rd != '0) q_lsu.push_back({i_lsu_rd, i_lsu_data});
      end
   end

   always @(negedge i_clk) begin
      log_wen[cyc % 4096]  = o_wen;
      log_addr[cyc % 4096] = o_waddr;
      log_data[cyc % 4096] = o_wdata;
      log_busy[cyc % 4096] = o_busy;
      if (o_wen) begin
         n_checks++;
         if (q_alu.size() > 0 && q_alu[0] == {o_waddr, o_wdata}) begin
            void'(q_alu.pop_front());
            matched++;
         end else if (q_lsu.size() > 0 && q_lsu[0] == {o_waddr, o_wdata}) begin
            void'(q_lsu.pop_front());
            matched++;
         end else begin
            n_fail++;
            $display("FAIL unexpected_write: got x%0d=0x%0h, no matching pending beat (alu %0d, lsu %0d queued)",
                     o_waddr, o_wdata, q_alu.size(), q_lsu.size());
         end
      end
   end

   task automatic idle_inputs();
      i_alu_valid = 1'b0; i_lsu_valid = 1'b0; i_issue_valid = 1'b0;
   endtask

   task automatic do_reset();
      @(posedge i_clk); #3;
      i_rst_n = 1'b0;
      idle_inputs();
      q_alu.delete(); q_lsu.delete();
      repeat (2) @(posedge i_clk);
      #2 i_rst_n = 1'b1;
   endtask

   task automatic next_cycle();
      @(posedge i_clk); #1;
   endtask

   task automatic drain(input string name);
      int unsigned t = 0;
      idle_inputs();
      while ((q_alu.size() != 0 || q_lsu.size() != 0) && t < 50) begin
         @(negedge i_clk); t++;
      end
      repeat (2) @(negedge i_clk);
      chk({name, "_alu_left"}, 64'(q_alu.size()), 64'd0);
      chk({name, "_lsu_left"}, 64'(q_lsu.size()), 64'd0);
   endtask

   int unsigned c0, c1;
   logic alu_hs, lsu_hs;
   int unsigned ai, li, seq;

   initial begin
      // Reset state
      #2;
      chk("rst_wen", 64'(o_wen), 64'd0);
      chk("rst_waddr", 64'(o_waddr), 64'd0);
      chk("rst_wdata", o_wdata, 64'd0);
      chk("rst_busy", 64'(o_busy), 64'd0);
      chk("rst_alu_ready", 64'(o_alu_ready), 64'd1);
      chk("rst_lsu_ready", 64'(o_lsu_ready), 64'd1);
      repeat (2) @(posedge i_clk);
      #2 i_rst_n = 1'b1;

      // ALU streaming rd 5..8
      next_cycle();
      c0 = cyc;
      for (int unsigned k = 0; k < 4; k++) begin
         i_alu_valid = 1'b1; i_alu_rd = AW'(5 + k); i_alu_data = 64'(17 * (k + 1));
         @(negedge i_clk);
         chk("stream_ready", 64'(o_alu_ready), 64'd1);
         next_cycle();
      end
      idle_inputs();
      repeat (4) next_cycle();
      chk("stream_pre", 64'(log_wen[(c0 + 1) % 4096]), 64'd0);
      for (int unsigned k = 0; k < 4; k++) begin
         chk("stream_wen", 64'(log_wen[(c0 + 2 + k) % 4096]), 64'd1);
         chk("stream_addr", 64'(log_addr[(c0 + 2 + k) % 4096]), 64'(5 + k));
         chk("stream_data", log_data[(c0 + 2 + k) % 4096], 64'(17 * (k + 1)));
      end
      chk("stream_post", 64'(log_wen[(c0 + 6) % 4096]), 64'd0);
      chk("stream_hold_addr", 64'(log_addr[(c0 + 6) % 4096]), 64'd8);

      // Contention twice: LSU first after reset, then ALU
      do_reset();
      for (int unsigned r = 0; r < 2; r++) begin
         next_cycle();
         c0 = cyc;
         i_alu_valid = 1'b1; i_alu_rd = 5'd3; i_alu_data = (r == 0) ? 64'hA : 64'hC;
         i_lsu_valid = 1'b1; i_lsu_rd = 5'd4; i_lsu_data = (r == 0) ? 64'hB : 64'hD;
         next_cycle();
         idle_inputs();
         repeat (4) next_cycle();
         chk("cont_wen0", 64'(log_wen[(c0 + 2) % 4096]), 64'd1);
         chk("cont_wen1", 64'(log_wen[(c0 + 3) % 4096]), 64'd1);
         chk("cont_first", 64'(log_addr[(c0 + 2) % 4096]), (r == 0) ? 64'd4 : 64'd3);
         chk("cont_first_data", log_data[(c0 + 2) % 4096], (r == 0) ? 64'hB : 64'hC);
         chk("cont_second", 64'(log_addr[(c0 + 3) % 4096]), (r == 0) ? 64'd3 : 64'd4);
         chk("cont_second_data", log_data[(c0 + 3) % 4096], (r == 0) ? 64'hA : 64'hD);
      end

      // Backpressure: 50 beats per channel, both continuously valid
      do_reset();
      matched = 0; ai = 0; li = 0; alu_hs = 1'b0; lsu_hs = 1'b0;
      for (int unsigned k = 0; k < 400 && (ai < 50 || li < 50); k++) begin
         next_cycle();
         if (alu_hs) ai++;
         if (lsu_hs) li++;
         i_alu_valid = (ai < 50); i_alu_rd = AW'(1 + ai % 31); i_alu_data = {32'hA1A1_0000, 32'(ai)};
         i_lsu_valid = (li < 50); i_lsu_rd = AW'(1 + (li * 7) % 31); i_lsu_data = {32'hB2B2_0000, 32'(li)};
         @(negedge i_clk);
         if (k >= 1 && ai < 48 && li < 48)
            chk("bp_ready_alternate", 64'(o_alu_ready ^ o_lsu_ready), 64'd1);
         alu_hs = i_alu_valid & o_alu_ready;
         lsu_hs = i_lsu_valid & o_lsu_ready;
      end
      drain("bp");
      chk("bp_beats", 64'(matched), 64'd100);

      // Randomized traffic including rd==0 beats and random issues
      alu_hs = 1'b0; lsu_hs = 1'b0; seq = 0;
      for (int unsigned k = 0; k < 400; k++) begin
         next_cycle();
         if (!i_alu_valid || alu_hs) begin
            i_alu_valid = ($urandom % 2) == 1; i_alu_rd = AW'($urandom % 32);
            i_alu_data = {8'hA7, 24'(seq), 32'($urandom)}; seq++;
         end
         if (!i_lsu_valid || lsu_hs) begin
            i_lsu_valid = ($urandom % 3) != 0; i_lsu_rd = AW'($urandom % 32);
            i_lsu_data = {8'hC9, 24'(seq), 32'($urandom)}; seq++;
         end
         i_issue_valid = ($urandom % 4) == 0; i_issue_rd = AW'($urandom % 32);
         @(negedge i_clk);
         alu_hs = i_alu_valid & o_alu_ready;
         lsu_hs = i_lsu_valid & o_lsu_ready;
      end
      drain("rand");

      // Scoreboard set/clear and same-edge set-wins
      do_reset();
      next_cycle();
      c0 = cyc;
      i_issue_valid = 1'b1; i_issue_rd = 5'd10;
      next_cycle();
      idle_inputs();
      c1 = cyc;
      i_alu_valid = 1'b1; i_alu_rd = 5'd10; i_alu_data = 64'h1010;
      next_cycle();
      idle_inputs();
      repeat (3) next_cycle();
      chk("sb_before_issue", 64'(log_busy[c0 % 4096][10]), 64'd0);
      chk("sb_set", 64'(log_busy[(c0 + 1) % 4096][10]), 64'd1);
      chk("sb_wen", 64'(log_wen[(c1 + 2) % 4096]), 64'd1);
      chk("sb_busy_during_wen", 64'(log_busy[(c1 + 2) % 4096][10]), 64'd1);
      chk("sb_cleared", 64'(log_busy[(c1 + 3) % 4096]), 64'd0);
      next_cycle();
      c0 = cyc;
      i_issue_valid = 1'b1; i_issue_rd = 5'd10;
      next_cycle();
      idle_inputs();
      next_cycle();
      c1 = cyc;
      i_alu_valid = 1'b1; i_alu_rd = 5'd10; i_alu_data = 64'h2020;
      next_cycle();
      idle_inputs();
      next_cycle();
      i_issue_valid = 1'b1; i_issue_rd = 5'd10;
      next_cycle();
      idle_inputs();
      repeat (2) next_cycle();
      chk("sb_same_wen", 64'(log_wen[(c1 + 2) % 4096]), 64'd1);
      chk("sb_set_wins", 64'(log_busy[(c1 + 3) % 4096]), 64'h400);
      chk("sb_set_wins_later", 64'(log_busy[(c1 + 4) % 4096]), 64'h400);

      // x0 handling
      do_reset();
      next_cycle();
      c0 = cyc;
      i_lsu_valid = 1'b1; i_lsu_rd = 5'd0; i_lsu_data = 64'hDEAD;
      i_issue_valid = 1'b1; i_issue_rd = 5'd0;
      @(negedge i_clk);
      chk("x0_ready", 64'(o_lsu_ready), 64'd1);
      next_cycle();
      idle_inputs();
      repeat (4) next_cycle();
      chk("x0_busy", 64'(log_busy[(c0 + 1) % 4096]), 64'd0);
      for (int unsigned k = 1; k < 5; k++)
         chk("x0_no_wen", 64'(log_wen[(c0 + k) % 4096]), 64'd0);
      chk("x0_drained", 64'(o_lsu_ready), 64'd1);

      // Reset mid-flight with a write on the port and the ALU buffer still full
      do_reset();
      next_cycle();
      i_issue_valid = 1'b1; i_issue_rd = 5'd9;
      next_cycle();
      i_issue_rd = 5'd10;
      next_cycle();
      i_issue_valid = 1'b0;
      i_alu_valid = 1'b1; i_alu_rd = 5'd9;  i_alu_data = 64'h99;
      i_lsu_valid = 1'b1; i_lsu_rd = 5'd10; i_lsu_data = 64'h1010;
      next_cycle();
      idle_inputs();
      next_cycle();
      #2;
      chk("mid_wen_before", 64'(o_wen), 64'd1);
      chk("mid_busy_before", 64'(o_busy), 64'h600);
      i_rst_n = 1'b0;
      #1;
      chk("mid_wen_async", 64'(o_wen), 64'd0);
      chk("mid_busy_async", 64'(o_busy), 64'd0);
      chk("mid_alu_dropped", 64'(o_alu_ready), 64'd1);
      q_alu.delete(); q_lsu.delete();
      repeat (2) @(posedge i_clk);
      #2 i_rst_n = 1'b1;
      c0 = cyc;
      repeat (8) next_cycle();
      for (int unsigned k = 0; k < 8; k++)
         chk("mid_no_write", 64'(log_wen[(c0 + k) % 4096]), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
